// File: rtl/mux_pkg.sv
// Shared limits and helpers for the pipelined N-to-1 word multiplexer.
package mux_pkg;

    localparam int MUX_N_MAX     = 64;
    localparam int MUX_WIDTH_MAX = 64;

    function automatic int clog2(input int value);
        int result = 0;
        int span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    localparam int MUX_SEL_W_MAX = clog2(MUX_N_MAX);

    // Widest result any legal instance can produce.
    typedef struct packed {
        logic                     err;
        logic [MUX_SEL_W_MAX-1:0] sel;
        logic [MUX_WIDTH_MAX-1:0] data;
    } mux_result_t;

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready buffer: output register O plus skid register K,
// sustaining one transfer per cycle with a registered in_ready.
module skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         o_valid_q, o_valid_d;
    logic [W-1:0] o_data_q,  o_data_d;
    logic         k_valid_q, k_valid_d;
    logic [W-1:0] k_data_q,  k_data_d;
    logic         ready_q,   ready_d;
    logic         accept;
    logic         drain;

    assign accept = in_valid && ready_q;
    assign drain  = o_valid_q && out_ready;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        k_valid_d = k_valid_q;
        k_data_d  = k_data_q;
        if (k_valid_q) begin
            if (drain) begin
                o_data_d  = k_data_q;
                k_valid_d = 1'b0;
            end
        end else if (!o_valid_q || drain) begin
            o_valid_d = accept;
            if (accept) begin
                o_data_d = in_data;
            end
        end else if (accept) begin
            k_data_d  = in_data;
            k_valid_d = 1'b1;
        end
        ready_d = !k_valid_d;
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            k_valid_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            k_valid_q <= k_valid_d;
            ready_q   <= ready_d;
        end
    end

    // NOTE: K's payload is never observed while k_valid_q is low, so it carries no reset.
    always_ff @(posedge clk) begin
        k_data_q <= k_data_d;
    end

    assign in_ready  = ready_q;
    assign out_valid = o_valid_q;
    assign out_data  = o_data_q;

endmodule

// File: rtl/mux_nto1_pipe.sv
// Parametrised N-to-1 word select with range check, feeding a two-entry
// valid/ready output buffer.
module mux_nto1_pipe
    import mux_pkg::*;
#(
    parameter  int N     = 32,
    parameter  int WIDTH = 32,
    localparam int SEL_W = clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic               out_err,
    output logic               out_valid,
    input  logic               out_ready
);

    typedef struct packed {
        logic             err;
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
    } result_t;

    if (N < 2 || N > MUX_N_MAX) begin : g_bad_n
        $error("mux_nto1_pipe: N=%0d outside 2..%0d", N, MUX_N_MAX);
    end
    if (WIDTH < 1 || WIDTH > MUX_WIDTH_MAX) begin : g_bad_width
        $error("mux_nto1_pipe: WIDTH=%0d outside 1..%0d", WIDTH, MUX_WIDTH_MAX);
    end
    if ($bits(result_t) > $bits(mux_result_t)) begin : g_bad_result
        $error("mux_nto1_pipe: result wider than mux_result_t");
    end

    result_t sel_res;
    result_t out_res;

    // Unmatched selects (>= N) fall through with zero data and err set.
    always_comb begin
        sel_res      = '0;
        sel_res.err  = 1'b1;
        sel_res.sel  = in_sel;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_res.err  = 1'b0;
                sel_res.data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    skid_buf #(
        .W($bits(result_t))
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (sel_res),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_res),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    assign out_err  = out_res.err;
    assign out_sel  = out_res.sel;
    assign out_data = out_res.data;

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Scoreboard bench for mux_nto1_pipe: instance 0 has N=32, instance 1 has N=20.
module tb_mux_nto1_pipe;

    typedef struct packed {
        logic        err;
        logic [4:0]  sel;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] words [2][32];
    logic [32*32-1:0] flat0;
    logic [20*32-1:0] flat1;
    logic [4:0]  in_sel    [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] out_data  [2];
    logic [4:0]  out_sel   [2];
    logic        out_err   [2];
    logic        out_valid [2];
    logic        out_ready [2];

    int   errors = 0;
    int   checks = 0;
    int   accepts [2] = '{0, 0};
    int   drains  [2] = '{0, 0};
    exp_t exp_q   [2][$];
    logic stalled [2] = '{1'b0, 1'b0};
    exp_t held    [2];

    always #5 clk = ~clk;

    always_comb begin
        flat0 = '0;
        flat1 = '0;
        for (int k = 0; k < 32; k++) flat0[k*32 +: 32] = words[0][k];
        for (int k = 0; k < 20; k++) flat1[k*32 +: 32] = words[1][k];
    end

    mux_nto1_pipe #(.N(32), .WIDTH(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_data(flat0), .in_sel(in_sel[0]),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .out_data(out_data[0]),
        .out_sel(out_sel[0]), .out_err(out_err[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0])
    );

    mux_nto1_pipe #(.N(20), .WIDTH(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_data(flat1), .in_sel(in_sel[1]),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .out_data(out_data[1]),
        .out_sel(out_sel[1]), .out_err(out_err[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the selected word if the index names one of the n words, else zero with err.
    function automatic exp_t ref_result(input int n, input logic [4:0] sel, input logic [31:0] w [32]);
        exp_t r;
        if (int'(sel) < n) r = '{err: 1'b0, sel: sel, data: w[sel]};
        else               r = '{err: 1'b1, sel: sel, data: 32'h0};
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: handshakes seen at the falling edge complete on the next rising edge.
    always @(negedge clk) begin
        exp_t got;
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                exp_q[d].delete();
                stalled[d] = 1'b0;
            end else begin
                got = '{err: out_err[d], sel: out_sel[d], data: out_data[d]};
                if (stalled[d]) begin
                    check($sformatf("stall_valid%0d", d), 64'(out_valid[d]), 64'd1);
                    check($sformatf("stall_hold%0d", d), 64'(got), 64'(held[d]));
                end
                if (out_valid[d] && out_ready[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check($sformatf("spurious_out%0d", d), 64'(out_valid[d]), 64'd0);
                    end else begin
                        e = exp_q[d].pop_front();
                        check($sformatf("drain%0d", d), 64'(got), 64'(e));
                        drains[d]++;
                    end
                end
                stalled[d] = out_valid[d] && !out_ready[d];
                held[d]    = got;
                if (in_valid[d] && in_ready[d]) begin
                    exp_q[d].push_back(ref_result((d == 0) ? 32 : 20, in_sel[d], words[d]));
                    accepts[d]++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        int t0;
        int t1;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            in_sel[d]    = '0;
            out_ready[d] = 1'b0;
            for (int k = 0; k < 32; k++) begin
                words[0][k] = 32'hA000_0000 + 32'(k);
                words[1][k] = 32'hB000_0000 + 32'(k);
            end
        end

        // Reset held for three cycles.
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check("reset_out_valid", 64'(out_valid[d]), 64'd0);
                check("reset_in_ready", 64'(in_ready[d]), 64'd0);
            end
        end
        check("reset_out_data", 64'(out_data[0]), 64'd0);
        check("reset_out_sel_err", 64'({out_sel[0], out_err[0]}), 64'd0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_first_edge", 64'(in_ready[0]), 64'd0);
        tick();
        check("ready_after_release0", 64'(in_ready[0]), 64'd1);
        check("ready_after_release1", 64'(in_ready[1]), 64'd1);

        // Back-to-back selects 0, 5, 31 with the consumer always ready.
        out_ready[0] = 1'b1;
        d0 = drains[0];
        in_valid[0] = 1'b1;
        in_sel[0] = 5'd0;  tick();
        in_sel[0] = 5'd5;  tick();
        in_sel[0] = 5'd31; tick();
        in_valid[0] = 1'b0;
        check("last_of_three_visible", 64'(out_data[0]), 64'hA000_001F);
        tick();
        check("one_result_per_cycle", 64'(drains[0] - d0), 64'd3);

        // Out-of-range and top-of-range selects on the N=20 instance.
        out_ready[1] = 1'b1;
        in_valid[1] = 1'b1;
        in_sel[1] = 5'd25; tick();
        check("oob_err", 64'(out_err[1]), 64'd1);
        check("oob_data", 64'(out_data[1]), 64'd0);
        check("oob_sel", 64'(out_sel[1]), 64'd25);
        in_sel[1] = 5'd19; tick();
        in_valid[1] = 1'b0;
        check("sel19_err", 64'(out_err[1]), 64'd0);
        check("sel19_data", 64'(out_data[1]), 64'hB000_0013);
        tick();

        // Fill O and K under back-pressure, then release.
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1;
        in_sel[0] = 5'd3; tick();
        check("ready_with_o_full", 64'(in_ready[0]), 64'd1);
        in_sel[0] = 5'd4; tick();
        in_valid[0] = 1'b0;
        check("ready_with_k_full", 64'(in_ready[0]), 64'd0);
        check("held_word3", 64'(out_data[0]), 64'hA000_0003);
        tick(); tick();
        check("still_word3", 64'(out_data[0]), 64'hA000_0003);
        check("still_not_ready", 64'(in_ready[0]), 64'd0);
        out_ready[0] = 1'b1;
        tick();
        check("ready_after_k_drain", 64'(in_ready[0]), 64'd1);
        check("k_moved_to_o", 64'(out_data[0]), 64'hA000_0004);
        tick();
        check("empty_after_drain", 64'(out_valid[0]), 64'd0);

        // Random traffic on both instances.
        t0 = accepts[0] + 1000;
        t1 = accepts[1] + 1000;
        for (int c = 0; c < 20000 && (accepts[0] < t0 || accepts[1] < t1); c++) begin
            for (int d = 0; d < 2; d++) begin
                in_valid[d]  = ($urandom_range(0, 1) == 1);
                out_ready[d] = ($urandom_range(0, 1) == 1);
                in_sel[d]    = 5'($urandom_range(0, 31));
                for (int k = 0; k < 32; k++) words[d][k] = $urandom;
            end
            tick();
        end
        check("random_accepts0", 64'(accepts[0] >= t0), 64'd1);
        check("random_accepts1", 64'(accepts[1] >= t1), 64'd1);
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        for (int c = 0; c < 10 && (exp_q[0].size() != 0 || exp_q[1].size() != 0); c++) tick();
        tick();
        check("random_left0", 64'(exp_q[0].size()), 64'd0);
        check("random_left1", 64'(exp_q[1].size()), 64'd0);
        check("random_idle0", 64'(out_valid[0]), 64'd0);

        // Reset with both entries full discards them.
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1;
        in_sel[0] = 5'd7; tick();
        in_sel[0] = 5'd8; tick();
        in_valid[0] = 1'b0;
        check("full_before_reset", 64'({out_valid[0], in_ready[0]}), 64'b10);
        rst_n = 1'b0;
        tick();
        check("reset_clears_valid", 64'(out_valid[0]), 64'd0);
        check("reset_clears_ready", 64'(in_ready[0]), 64'd0);
        rst_n = 1'b1;
        tick();
        check("ready_after_second_reset", 64'(in_ready[0]), 64'd1);
        check("nothing_after_reset", 64'(out_valid[0]), 64'd0);
        out_ready[0] = 1'b1;
        in_valid[0] = 1'b1;
        in_sel[0] = 5'd9; tick();
        in_valid[0] = 1'b0;
        tick(); tick();
        check("post_reset_drains_only_new", 64'(exp_q[0].size()), 64'd0);
        check("post_reset_idle", 64'(out_valid[0]), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_nto1_pipe.md
Name: mux_nto1_pipe

Overview:
- Parametrised N-to-1 word multiplexer with a registered output and a valid/ready handshake on both sides. Successor to the fixed 32x32-bit combinational select.
- Sits between register-file/forwarding sources and datapath consumers that may stall.
- Holds back-pressured results in a 2-entry output buffer (output register plus skid register), so it sustains 1 transfer/cycle.
- Flags out-of-range selects instead of producing undefined data.

Parameters:
- N, 32, number of input words (2..64; need not be a power of two).
- WIDTH, 32, bits per word (1..64).
- SEL_W, derived localparam = ceil(log2(N)), select width; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  N*WIDTH  flattened inputs; word k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  select index.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request this cycle.
- out_data  output  WIDTH  selected word.
- out_sel  output  SEL_W  select that produced out_data.
- out_err  output  1  select was >= N.
- out_valid  output  1  output holds a result.
- out_ready  input  1  consumer accepts the result this cycle.

Behaviour:
- Clocking and reset: one clock; reset is synchronous, active-low, sampled at the rising edge of clk.
- Reset values while rst_n=0:
  - out_valid=0, out_data=0, out_sel=0, out_err=0, in_ready=0.
  - Both buffer entries are marked empty.
  - in_ready rises to 1 on the first edge after rst_n returns high.
- Transfers:
  - Accept occurs when in_valid && in_ready at an edge.
  - Drain occurs when out_valid && out_ready at an edge.
- Selection:
  - The selection happens in the accept cycle. The result is in_data[in_sel*WIDTH +: WIDTH] and is captured with in_sel.
  - If in_sel >= N, the data captured is 0 and err=1.
- Latency:
  - The result is visible on out_* on the edge after accept (1 cycle) when the output register is empty or draining.
  - Back-to-back accepts with out_ready held at 1 give 1 result/cycle, in order.
- Buffer transitions (O = output register, K = skid register):
  - O empty, accept: the result goes to O.
  - O full, drain and accept, K empty: the new result goes to O.
  - O full, no drain, accept: the result goes to K; in_ready=0 from the next cycle.
  - K full and drain: K moves to O, K empties, in_ready=1 from the next cycle.
  - K full and no drain: nothing changes; O and K hold.
- in_ready:
  - Registered, equal to "K empty" after the edge.
  - Never depends combinationally on in_valid or out_ready.
- Output stability: out_data, out_sel and out_err stay stable while out_valid=1 and out_ready=0.
- No loss or duplication: every accepted request produces exactly one drained result, in FIFO order.
- Invariant: K full implies O full.
- Reset mid-operation discards all buffered results; none is emitted after reset.
- out_err results are ordinary results: they are buffered and handshaken like any other.

Decomposition:
- Package mux_pkg:
  - clog2 constant function.
  - MUX_N_MAX=64 and MUX_WIDTH_MAX=64, checked by elaboration-time asserts.
  - A packed result struct/typedef {err, sel, data}.
- Sub-module skid_buf (parametrised by payload width):
  - Contains O, K and the ready/valid control.
- Top level: the combinational indexed select and range check, feeding skid_buf's input.

Test Plan:
- Reset, in_valid=0 for 3 cycles -> out_valid=0, in_ready=0 during reset, in_ready=1 on the first edge after release.
- N=32, WIDTH=32, word k = 32'hA000_0000+k, out_ready=1; accept sel=0,5,31 on consecutive cycles -> out_data = A0000000, A0000005, A000001F on the next three cycles, out_err=0, 1 result/cycle.
- N=20, in_sel=5'd25 -> out_data=0, out_err=1, out_sel=25. In the same test, in_sel=19 -> word 19, out_err=0.
- out_ready=0, accept sel=3 then sel=4 -> in_ready=0 after the second accept, out_data (word 3) stays stable; raise out_ready -> word 3 then word 4 are drained, in_ready=1 on the cycle after word 3 drains.
- Random in_valid/out_ready (50% each), 1000 requests -> scoreboard confirms in-order, lossless, duplicate-free output and that out_* stay stable during stalls.
- Assert rst_n=0 with both entries full -> out_valid=0 after that edge; after release, only new requests appear.
